mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single external SRAM between instruction fetch (IF) and data access (MEM stage).
//  Data traffic from EX/MEM (mem_op = MEM_READ_OP / MEM_WRITE_OP) always wins; IF is held off until the data access completes.
//  Sequences SRAM control strobes with programmable wait states and returns a one-cycle ack to the requester.
// PARAMETERS
//  ADDR_W   18  SRAM address width; the upper (ADDR_W-16) bits are driven 0
//  RD_WAIT  1   cycles ce_n/oe_n held low per read (>=1)
//  WR_WAIT  1   cycles we_n held low per write (>=1)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous reset, active-high
//  if_req       in   1       fetch request; level, held until if_ack
//  if_addr      in   16      fetch address
//  if_rdata     out  16      fetched word; registered, valid from if_ack onward
//  if_ack       out  1       one-cycle fetch-complete pulse
//  mem_op       in   2       MEM_READ_OP / MEM_WRITE_OP / other = none; held until mem_ack
//  mem_addr     in   16      data address
//  mem_wdata    in   16      store data
//  mem_rdata    out  16      load data; registered, valid from mem_ack onward
//  mem_ack      out  1       one-cycle data-complete pulse
//  busy         out  1       high in every state except IDLE
//  ram_addr     out  ADDR_W  SRAM address
//  ram_dq_o     out  16      SRAM write data
//  ram_dq_oe    out  1       tri-state enable for ram_dq_o (top level builds the inout)
//  ram_dq_i     in   16      SRAM read data
//  ram_ce_n     out  1       chip enable, active-low
//  ram_oe_n     out  1       output enable, active-low
//  ram_we_n     out  1       write enable, active-low
// BEHAVIOUR
//  Reset (async): state=IDLE; ce_n/oe_n/we_n=1; dq_oe=0; ram_addr, ram_dq_o, if_rdata, mem_rdata=0; acks=0; wait counter=0.
//  Requests are sampled only in IDLE. Priority: data > fetch. Address, op and wdata are latched on leaving IDLE; later input changes are ignored until DONE.
//  States:
//   IDLE  -> RD (data read or fetch) | WR_SU (data write)
//   RD    -> ce_n=oe_n=0, dq_oe=0 for RD_WAIT cycles; on the last cycle register ram_dq_i into the owner's rdata; -> DONE
//   WR_SU -> ce_n=0, dq_oe=1, we_n=1, 1 cycle; -> WR_P
//   WR_P  -> we_n=0 for WR_WAIT cycles; -> WR_H
//   WR_H  -> we_n=1, dq_oe=1, 1 cycle (data hold); -> DONE
//   DONE  -> owner's ack=1, strobes deasserted; -> IDLE
//  Latency from request sampled in IDLE to ack: read = RD_WAIT+1 cycles; write = WR_WAIT+3 cycles.
//  Gap: at least one IDLE cycle between transactions. A requester deasserts on ack, so no double service.
//  Simultaneous if_req and data op: data is served first; if_req stays pending, gets no ack, and is served next.
//  mem_op other than READ/WRITE counts as no request.
//  Bus safety: dq_oe=1 only in WR_SU/WR_P/WR_H; oe_n and we_n are never low in the same cycle.
//  Reset mid-transaction: immediate return to reset values; the aborted access gets no ack.
// CONFIGURATION
//  ARB_STALL_CNT_EN defined: adds output stall_cnt[15:0], a saturating count of cycles with if_req=1 and state!=IDLE or data winning; cleared by rst.
//  Undefined: no port, no counter logic.
// STRUCTURE
//  Shared defines file: existing MEM_READ_OP/MEM_WRITE_OP; add ARB_IDLE/ARB_RD/ARB_WR_SU/ARB_WR_P/ARB_WR_H/ARB_DONE (3-bit) encodings.
//  One sub-module: arb_wait_timer (load value, decrement, done flag), shared by RD and WR_P.
// TESTING
//  Fetch only: if_req=1, if_addr=0x4000, SRAM model word 0x1234, RD_WAIT=1 -> if_ack 2 cycles later, if_rdata=0x1234, we_n stays 1.
//  Write then read: write 0xBEEF to 0x0010, then read 0x0010 -> mem_rdata=0xBEEF; WR_WAIT=2 gives write ack after 5 cycles; dq_oe=0 during the read.
//  Contention: if_req and MEM_READ_OP asserted in the same cycle -> mem_ack first, then if_ack; never both acks in one cycle.
//  Wait states: RD_WAIT=3 -> oe_n low exactly 3 cycles; ack 4 cycles after the request.
//  Reset in WR_P: rst pulse -> we_n=1, dq_oe=0 asynchronously; no mem_ack; the next request is served normally.
//  ARB_STALL_CNT_EN: hold if_req for 10 cycles against a data write with WR_WAIT=1 -> stall_cnt equals the cycles denied; saturates at 0xFFFF.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared op codes, FSM state encodings and request helpers for the SRAM arbiter.
package mem_arbiter_pkg;
    localparam logic [1:0] MEM_READ_OP  = 2'b01;
    localparam logic [1:0] MEM_WRITE_OP = 2'b10;
    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_RD    = 3'd1,
        ARB_WR_SU = 3'd2,
        ARB_WR_P  = 3'd3,
        ARB_WR_H  = 3'd4,
        ARB_DONE  = 3'd5
    } arb_state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t;
    function automatic logic is_data_op(input logic [1:0] op);
        return op == MEM_READ_OP || op == MEM_WRITE_OP;
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes (fetch + data) and SRAM pin bundle shared by arbiter and environment.
interface mem_arbiter_if #(parameter int ADDR_W = 18);
    logic              if_req;
    logic [15:0]       if_addr;
    logic [15:0]       if_rdata;
    logic              if_ack;
    logic [1:0]        mem_op;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ack;
    logic              busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_dq_o;
    logic              ram_dq_oe;
    logic [15:0]       ram_dq_i;
    logic              ram_ce_n;
    logic              ram_oe_n;
    logic              ram_we_n;
    modport slave (
        input  if_req, if_addr, mem_op, mem_addr, mem_wdata, ram_dq_i,
        output if_rdata, if_ack, mem_rdata, mem_ack, busy,
               ram_addr, ram_dq_o, ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n
    );
    modport master (
        output if_req, if_addr, mem_op, mem_addr, mem_wdata, ram_dq_i,
        input  if_rdata, if_ack, mem_rdata, mem_ack, busy,
               ram_addr, ram_dq_o, ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n
    );
endinterface

// File: rtl/mem_arbiter_wait_timer.sv
// arb_wait_timer: loadable down-counter; done is high once the count has reached zero.
module arb_wait_timer #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (load) cnt <= value;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign done = cnt == '0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM between fetch and data ports (data wins) with programmable wait states.
// Optional ARB_STALL_CNT_EN adds stall_cnt, a saturating count of fetch-denied cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 18,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic clk,
    input  logic rst,
    mem_arbiter_if.slave bus
`ifdef ARB_STALL_CNT_EN
    , output logic [15:0] stall_cnt
`endif
);
    arb_state_t state;
    arb_owner_t owner;
    logic       t_load;
    logic       t_done;
    logic [7:0] t_val;

    // Timer preloads while idle (read length) and during write setup (pulse length).
    assign t_load = state == ARB_IDLE || state == ARB_WR_SU;
    assign t_val  = state == ARB_WR_SU ? 8'(WR_WAIT - 1) : 8'(RD_WAIT - 1);
    assign bus.busy = state != ARB_IDLE;

    arb_wait_timer #(.W(8)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (t_load),
        .value (t_val),
        .done  (t_done)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state         <= ARB_IDLE;
            owner         <= OWN_FETCH;
            bus.ram_addr  <= '0;
            bus.ram_dq_o  <= '0;
            bus.ram_dq_oe <= 1'b0;
            bus.ram_ce_n  <= 1'b1;
            bus.ram_oe_n  <= 1'b1;
            bus.ram_we_n  <= 1'b1;
            bus.if_rdata  <= '0;
            bus.mem_rdata <= '0;
            bus.if_ack    <= 1'b0;
            bus.mem_ack   <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE:
                    if (is_data_op(bus.mem_op)) begin
                        state         <= bus.mem_op == MEM_WRITE_OP ? ARB_WR_SU : ARB_RD;
                        owner         <= OWN_DATA;
                        bus.ram_addr  <= ADDR_W'(bus.mem_addr);
                        bus.ram_dq_o  <= bus.mem_wdata;
                        bus.ram_ce_n  <= 1'b0;
                        bus.ram_oe_n  <= bus.mem_op == MEM_WRITE_OP;
                        bus.ram_dq_oe <= bus.mem_op == MEM_WRITE_OP;
                    end else if (bus.if_req) begin
                        state        <= ARB_RD;
                        owner        <= OWN_FETCH;
                        bus.ram_addr <= ADDR_W'(bus.if_addr);
                        bus.ram_ce_n <= 1'b0;
                        bus.ram_oe_n <= 1'b0;
                    end
                ARB_RD:
                    if (t_done) begin
                        state        <= ARB_DONE;
                        bus.ram_ce_n <= 1'b1;
                        bus.ram_oe_n <= 1'b1;
                        if (owner == OWN_DATA) bus.mem_rdata <= bus.ram_dq_i;
                        else bus.if_rdata <= bus.ram_dq_i;
                        bus.mem_ack  <= owner == OWN_DATA;
                        bus.if_ack   <= owner == OWN_FETCH;
                    end
                ARB_WR_SU: begin
                    state        <= ARB_WR_P;
                    bus.ram_we_n <= 1'b0;
                end
                ARB_WR_P:
                    if (t_done) begin
                        state        <= ARB_WR_H;
                        bus.ram_we_n <= 1'b1;
                    end
                ARB_WR_H: begin
                    state         <= ARB_DONE;
                    bus.ram_ce_n  <= 1'b1;
                    bus.ram_dq_oe <= 1'b0;
                    bus.mem_ack   <= 1'b1;
                end
                ARB_DONE: begin
                    state       <= ARB_IDLE;
                    bus.if_ack  <= 1'b0;
                    bus.mem_ack <= 1'b0;
                end
                default: state <= ARB_IDLE;
            endcase
        end

`ifdef ARB_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) stall_cnt <= '0;
        else if (bus.if_req && (state != ARB_IDLE || is_data_op(bus.mem_op)) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule
